// File: rtl/door_pkg.sv
// Shared state encoding and width helpers for the door sequencer.
package door_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_PANIC = 3'd4
  } door_state_e;

  // Index/count width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/door_seq_ctrl_if.sv
// Request/status bundle between the door sequencer and its environment.
interface door_seq_ctrl_if #(
  parameter int N_REQ      = 2,
  parameter int SEC_W      = 4,
  parameter int MAX_REOPEN = 3
);
  import door_pkg::*;

  localparam int SRC_W  = clog2_min1(N_REQ);
  localparam int RCNT_W = clog2_min1(MAX_REOPEN + 1);

  logic [N_REQ-1:0]   req;
  logic               panic;
  logic               panic_clr;
  logic               obstruct;
  logic [STATE_W-1:0] state;
  logic [SEC_W-1:0]   sec;
  logic               motor_open;
  logic               motor_close;
  logic               alarm;
  logic [SRC_W-1:0]   req_src;
  logic [RCNT_W-1:0]  reopen_cnt;

  modport master (
    output req, panic, panic_clr, obstruct,
    input  state, sec, motor_open, motor_close, alarm, req_src, reopen_cnt
  );

  modport slave (
    input  req, panic, panic_clr, obstruct,
    output state, sec, motor_open, motor_close, alarm, req_src, reopen_cnt
  );

endinterface

// File: rtl/door_seq_ctrl_sec_timer.sv
// Prescaler plus saturating seconds counter; i_clr restarts both at the same edge.
module sec_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [SEC_W-1:0] o_sec
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] r_pre;
  logic [SEC_W-1:0] r_sec;
  logic             w_wrap;

  assign w_wrap = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_pre <= '0;
      r_sec <= '0;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap && (r_sec != '1)) begin
        r_sec <= r_sec + 1'b1;
      end
    end
  end

  assign o_sec = r_sec;

endmodule

// File: rtl/door_seq_ctrl.sv
// Door open/wait/close sequencer with hold-open, obstruction reopen and panic lockout.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | door closed, waiting for a request
// ST_OPEN  | motor driving open for T_OPEN seconds
// ST_WAIT  | door held open for T_WAIT seconds, requests extend the hold
// ST_CLOSE | motor driving closed for T_CLOSE seconds, may reopen
// ST_PANIC | alarm latched until panic_clr without panic
module door_seq_ctrl
  import door_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_W         = 4,
  parameter int T_OPEN        = 3,
  parameter int T_WAIT        = 5,
  parameter int T_CLOSE       = 3,
  parameter int MAX_REOPEN    = 3
) (
  input logic            clk,
  input logic            rst,
  door_seq_ctrl_if.slave bus
);

  localparam int SRC_W  = clog2_min1(N_REQ);
  localparam int RCNT_W = clog2_min1(MAX_REOPEN + 1);
  localparam longint SEC_LIM = longint'(1) << SEC_W;

  if (N_REQ < 1) begin : g_bad_nreq
    $error("door_seq_ctrl: N_REQ must be >= 1");
  end
  if (TICKS_PER_SEC < 1) begin : g_bad_tps
    $error("door_seq_ctrl: TICKS_PER_SEC must be >= 1");
  end
  if (T_OPEN < 1 || longint'(T_OPEN) >= SEC_LIM) begin : g_bad_topen
    $error("door_seq_ctrl: T_OPEN out of range for SEC_W");
  end
  if (T_WAIT < 1 || longint'(T_WAIT) >= SEC_LIM) begin : g_bad_twait
    $error("door_seq_ctrl: T_WAIT out of range for SEC_W");
  end
  if (T_CLOSE < 1 || longint'(T_CLOSE) >= SEC_LIM) begin : g_bad_tclose
    $error("door_seq_ctrl: T_CLOSE out of range for SEC_W");
  end

  door_state_e       r_state;
  logic [SRC_W-1:0]  r_req_src;
  logic [RCNT_W-1:0] r_reopen_cnt;
  logic              r_motor_open;
  logic              r_motor_close;
  logic              r_alarm;

  door_state_e       w_nxt;
  logic [SRC_W-1:0]  w_src_nxt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic [SRC_W-1:0]  w_low_idx;
  logic [SEC_W-1:0]  w_sec;
  logic [SEC_W-1:0]  w_limit;
  logic              w_any_req;
  logic              w_timeout;
  logic              w_hold;
  logic              w_clr;

  sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .SEC_W        (SEC_W)
  ) u_sec_timer (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .o_sec(w_sec)
  );

  assign w_any_req = |bus.req;

  always_comb begin
    w_low_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) w_low_idx = SRC_W'(i);
    end
  end

  always_comb begin
    w_limit = '1;
    case (r_state)
      ST_OPEN:  w_limit = SEC_W'(T_OPEN);
      ST_WAIT:  w_limit = SEC_W'(T_WAIT);
      ST_CLOSE: w_limit = SEC_W'(T_CLOSE);
      default:  w_limit = '1;
    endcase
  end

  assign w_timeout = (w_sec >= w_limit);

  always_comb begin
    w_nxt      = r_state;
    w_src_nxt  = r_req_src;
    w_rcnt_nxt = r_reopen_cnt;
    w_hold     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.panic) begin
          w_nxt = ST_PANIC;
        end else if (w_any_req) begin
          w_nxt     = ST_OPEN;
          w_src_nxt = w_low_idx;
        end
      end
      ST_OPEN: begin
        if (bus.panic)      w_nxt = ST_PANIC;
        else if (w_timeout) w_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.panic)      w_nxt  = ST_PANIC;
        else if (w_any_req) w_hold = 1'b1;
        else if (w_timeout) w_nxt  = ST_CLOSE;
      end
      ST_CLOSE: begin
        // A reopen request beats a timeout landing in the same cycle.
        if (bus.panic) begin
          w_nxt = ST_PANIC;
        end else if (bus.obstruct || w_any_req) begin
          if (r_reopen_cnt < RCNT_W'(MAX_REOPEN)) begin
            w_nxt      = ST_OPEN;
            w_rcnt_nxt = r_reopen_cnt + 1'b1;
          end else begin
            w_nxt = ST_PANIC;
          end
        end else if (w_timeout) begin
          w_nxt      = ST_IDLE;
          w_rcnt_nxt = '0;
        end
      end
      ST_PANIC: begin
        if (bus.panic_clr && !bus.panic) begin
          w_nxt      = ST_OPEN;
          w_rcnt_nxt = '0;
        end
      end
      default: w_nxt = ST_PANIC;
    endcase
  end

  assign w_clr = w_hold || (w_nxt != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_req_src     <= '0;
      r_reopen_cnt  <= '0;
      r_motor_open  <= 1'b0;
      r_motor_close <= 1'b0;
      r_alarm       <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_req_src     <= w_src_nxt;
      r_reopen_cnt  <= w_rcnt_nxt;
      r_motor_open  <= (w_nxt == ST_OPEN);
      r_motor_close <= (w_nxt == ST_CLOSE);
      r_alarm       <= (w_nxt == ST_PANIC);
    end
  end

  assign bus.state       = r_state;
  assign bus.sec         = w_sec;
  assign bus.req_src     = r_req_src;
  assign bus.reopen_cnt  = r_reopen_cnt;
  assign bus.motor_open  = r_motor_open;
  assign bus.motor_close = r_motor_close;
  assign bus.alarm       = r_alarm;

endmodule

// File: tb/tb_door_seq_ctrl.sv
// Directed bench for door_seq_ctrl: single-cycle vector table plus timed sequences.
module tb_door_seq_ctrl;

  localparam int N_REQ = 3;
  localparam int TPS   = 4;
  localparam int SEC_W = 4;
  localparam int T_OP  = 2;
  localparam int T_WT  = 3;
  localparam int T_CL  = 2;
  localparam int MAXR  = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CLOSE = 3'd3;
  localparam logic [2:0] S_PANIC = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  door_seq_ctrl_if #(.N_REQ(N_REQ), .SEC_W(SEC_W), .MAX_REOPEN(MAXR)) bus ();

  door_seq_ctrl #(
    .N_REQ(N_REQ), .TICKS_PER_SEC(TPS), .SEC_W(SEC_W),
    .T_OPEN(T_OP), .T_WAIT(T_WT), .T_CLOSE(T_CL), .MAX_REOPEN(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       panic;
    logic       clr;
    logic       obs;
    logic [2:0] st;
    logic [3:0] sec;
    logic       mo;
    logic       mc;
    logic       al;
    logic [1:0] src;
    logic [1:0] rc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [2:0] q, logic p, logic c, logic o,
                              logic [2:0] st, logic [3:0] sec, logic [1:0] src, logic [1:0] rc);
    vec_t v;
    v.rst = r; v.req = q; v.panic = p; v.clr = c; v.obs = o;
    v.st = st; v.sec = sec; v.src = src; v.rc = rc;
    v.mo = (st == S_OPEN);
    v.mc = (st == S_CLOSE);
    v.al = (st == S_PANIC);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (bus.motor_open && bus.motor_close) begin
      failures++;
      $display("FAIL motor_excl: got open=1 close=1 expected at most one");
    end
  endtask

  task automatic run_until(input logic [2:0] target, input int budget, output int n);
    n = 0;
    while (bus.state != target && n < budget) begin
      step();
      n++;
    end
    if (bus.state != target) begin
      failures++;
      $display("FAIL run_until: state got %0d expected %0d within %0d cycles", bus.state, target, budget);
    end
  endtask

  task automatic pulse_req(input logic [2:0] v);
    bus.req = v;
    step();
    bus.req = '0;
  endtask

  initial begin
    logic [13:0] act, exp;
    int n;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] act, exp;
    int n;

    rst = 1'b1;
    bus.req = '0; bus.panic = 1'b0; bus.panic_clr = 1'b0; bus.obstruct = 1'b0;
    step();

    //           rst  req     pn   clr  obs  state    sec src rc
    tv.push_back(mk(1, 3'b000, 0, 0, 0, S_IDLE,  0, 0, 0));
    tv.push_back(mk(1, 3'b000, 1, 0, 0, S_IDLE,  0, 0, 0));
    tv.push_back(mk(0, 3'b000, 0, 0, 0, S_IDLE,  0, 0, 0));
    tv.push_back(mk(0, 3'b110, 0, 0, 0, S_OPEN,  0, 1, 0));
    tv.push_back(mk(0, 3'b000, 0, 0, 0, S_OPEN,  0, 1, 0));
    tv.push_back(mk(0, 3'b000, 1, 0, 0, S_PANIC, 0, 1, 0));
    tv.push_back(mk(0, 3'b000, 1, 1, 0, S_PANIC, 0, 1, 0));
    tv.push_back(mk(0, 3'b000, 0, 1, 0, S_OPEN,  0, 1, 0));
    tv.push_back(mk(1, 3'b000, 0, 0, 0, S_IDLE,  0, 0, 0));
    tv.push_back(mk(0, 3'b100, 0, 0, 0, S_OPEN,  0, 2, 0));
    tv.push_back(mk(0, 3'b000, 0, 0, 1, S_OPEN,  0, 2, 0));
    tv.push_back(mk(0, 3'b011, 0, 0, 0, S_OPEN,  0, 2, 0));
    tv.push_back(mk(1, 3'b000, 0, 0, 0, S_IDLE,  0, 0, 0));
    tv.push_back(mk(0, 3'b111, 0, 0, 0, S_OPEN,  0, 0, 0));
    tv.push_back(mk(0, 3'b001, 1, 0, 0, S_PANIC, 0, 0, 0));
    tv.push_back(mk(1, 3'b000, 0, 0, 0, S_IDLE,  0, 0, 0));
    tv.push_back(mk(0, 3'b100, 1, 0, 0, S_PANIC, 0, 0, 0));
    tv.push_back(mk(1, 3'b000, 0, 0, 0, S_IDLE,  0, 0, 0));

    foreach (tv[i]) begin
      rst = tv[i].rst;
      bus.req = tv[i].req; bus.panic = tv[i].panic;
      bus.panic_clr = tv[i].clr; bus.obstruct = tv[i].obs;
      step();
      act = {bus.state, bus.sec, bus.motor_open, bus.motor_close, bus.alarm, bus.req_src, bus.reopen_cnt};
      exp = {tv[i].st, tv[i].sec, tv[i].mo, tv[i].mc, tv[i].al, tv[i].src, tv[i].rc};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL vec%0d: got st=%0d sec=%0d mo=%b mc=%b al=%b src=%0d rc=%0d expected st=%0d sec=%0d mo=%b mc=%b al=%b src=%0d rc=%0d",
                 i, bus.state, bus.sec, bus.motor_open, bus.motor_close, bus.alarm, bus.req_src, bus.reopen_cnt,
                 tv[i].st, tv[i].sec, tv[i].mo, tv[i].mc, tv[i].al, tv[i].src, tv[i].rc);
      end
    end
    rst = 1'b0;
    bus.req = '0; bus.panic = 1'b0; bus.panic_clr = 1'b0; bus.obstruct = 1'b0;

    // Full undisturbed cycle: OPEN 9, WAIT 13, CLOSE 9 cycles.
    pulse_req(3'b110);
    chk("a_open_state", bus.state, S_OPEN);
    chk("a_req_src", bus.req_src, 1);
    run_until(S_WAIT, 40, n);
    chk("a_open_cycles", n, T_OP * TPS + 1);
    chk("a_wait_sec0", bus.sec, 0);
    run_until(S_CLOSE, 40, n);
    chk("a_wait_cycles", n, T_WT * TPS + 1);
    chk("a_motor_close", bus.motor_close, 1);
    run_until(S_IDLE, 40, n);
    chk("a_close_cycles", n, T_CL * TPS + 1);
    chk("a_idle_rc", bus.reopen_cnt, 0);

    // Hold-open extension at WAIT sec=2.
    pulse_req(3'b001);
    chk("b_open_src", bus.req_src, 0);
    run_until(S_WAIT, 40, n);
    repeat (8) step();
    chk("b_wait_sec2", bus.sec, 2);
    pulse_req(3'b010);
    chk("b_hold_state", bus.state, S_WAIT);
    chk("b_hold_sec0", bus.sec, 0);
    run_until(S_CLOSE, 40, n);
    chk("b_hold_cycles", n, T_WT * TPS + 1);

    // Obstruction on three consecutive closings.
    bus.obstruct = 1'b1; step(); bus.obstruct = 1'b0;
    chk("c_reopen1_state", bus.state, S_OPEN);
    chk("c_reopen1_cnt", bus.reopen_cnt, 1);
    run_until(S_CLOSE, 60, n);
    chk("c_reclose_cycles", n, (T_OP + T_WT) * TPS + 2);
    bus.obstruct = 1'b1; step(); bus.obstruct = 1'b0;
    chk("c_reopen2_state", bus.state, S_OPEN);
    chk("c_reopen2_cnt", bus.reopen_cnt, 2);
    run_until(S_CLOSE, 60, n);
    bus.obstruct = 1'b1; step(); bus.obstruct = 1'b0;
    chk("c_third_state", bus.state, S_PANIC);
    chk("c_third_alarm", bus.alarm, 1);

    // Panic exit, then panic on the OPEN timeout cycle.
    bus.panic_clr = 1'b1; step(); bus.panic_clr = 1'b0;
    chk("d_exit_state", bus.state, S_OPEN);
    chk("d_exit_rc", bus.reopen_cnt, 0);
    repeat (8) step();
    chk("d_open_sec2", bus.sec, 2);
    bus.panic = 1'b1; step(); bus.panic = 1'b0;
    chk("d_panic_timeout", bus.state, S_PANIC);
    bus.panic = 1'b1; bus.panic_clr = 1'b1; step();
    bus.panic = 1'b0; bus.panic_clr = 1'b0;
    chk("d_clr_with_panic", bus.state, S_PANIC);
    bus.panic_clr = 1'b1; step(); bus.panic_clr = 1'b0;
    chk("d_clr_alone", bus.state, S_OPEN);
    chk("d_clr_alone_rc", bus.reopen_cnt, 0);
    chk("d_clr_motor", bus.motor_open, 1);

    // Request reopen coinciding with CLOSE timeout; req_src not relatched.
    run_until(S_CLOSE, 60, n);
    repeat (8) step();
    chk("f_close_sec2", bus.sec, 2);
    pulse_req(3'b010);
    chk("f_reopen_state", bus.state, S_OPEN);
    chk("f_reopen_rc", bus.reopen_cnt, 1);
    chk("f_src_kept", bus.req_src, 0);

    // Reset mid-CLOSE.
    run_until(S_CLOSE, 60, n);
    repeat (4) step();
    chk("e_close_sec1", bus.sec, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("e_rst_state", bus.state, S_IDLE);
    chk("e_rst_sec", bus.sec, 0);
    chk("e_rst_outs", {bus.motor_open, bus.motor_close, bus.alarm}, 0);
    chk("e_rst_rc", bus.reopen_cnt, 0);
    step();
    pulse_req(3'b001);
    chk("e_after_rst_open", bus.state, S_OPEN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
